if_redirect_arbiter: RTL and testbench
======================================

// Module: if_redirect_arbiter
// PURPOSE
//  Sequences every fetch redirect and predictor update into the IF stage.
//  Flush, restart and predictor-update (BTB/gshare/RAS) sources arbitrate here; output is one redirect per cycle.
//  Guarantees ordering: updates accepted at or before a restart reach the predictor before that restart's redirect.
//  Buffers updates in a small FIFO.
// PARAMETERS
//  PC_BITS            32  width of all PCs
//  UPD_FIFO_DEPTH     4   predictor-update FIFO entries; power of two, >=2
//  FLUSH_STALL_CYCLES 2   cycles fetch_stall_o is held after a flush redirect; >=1
// PORTS
//  clk               in   1        clock
//  rst_n             in   1        synchronous active-low reset
//  flush_valid_i     in   1        flush request, always accepted
//  flush_pc_i        in   PC_BITS  flush target
//  restart_valid_i   in   1        restart request (valid/ready)
//  restart_ready_o   out  1        restart accepted when valid&ready
//  restart_pc_i      in   PC_BITS  restart target
//  restart_cause_i   in   3        redirect_cause_e; INV_INSTR/INV_PRED/CALL/RET only
//  pr_valid_i        in   1        predictor update offered
//  pr_ready_o        out  1        FIFO not full
//  pr_update_i       in   72       predictor_update struct
//  upd_valid_o       out  1        update to predictor
//  upd_ready_i       in   1        predictor consumes update
//  upd_o             out  72       predictor_update struct
//  redirect_valid_o  out  1        one-cycle redirect pulse to PC generator
//  redirect_pc_o     out  PC_BITS  redirect target
//  redirect_cause_o  out  3        redirect_cause_e
//  fetch_stall_o     out  1        IF must not issue fetches
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; FIFO empty; pend_cnt=0; redirect_valid_o=0, redirect_pc_o=0,
//   redirect_cause_o=NONE, upd_valid_o=0, fetch_stall_o=0; pr_ready_o=0 and restart_ready_o=0 while rst_n=0.
//  Reset mid-operation drops pending restart and FIFO contents.
//  FSM states: IDLE, PEND (restart waiting for older updates), HOLD (post-flush stall).
//  restart_ready_o = rst_n & (state==IDLE) & !flush_valid_i.
//  Flush (highest priority, any state):
//   - next cycle redirect_valid_o=1, pc=flush_pc_i, cause=FLUSH;
//   - cancels any pending restart;
//   - -> HOLD, hold_cnt=FLUSH_STALL_CYCLES;
//   - fetch_stall_o=1 from the redirect cycle through the last HOLD cycle; HOLD -> IDLE when hold_cnt reaches 0;
//   - flush in HOLD re-issues a redirect and reloads hold_cnt;
//   - FIFO is not flushed (updates come from commit).
//  Restart accept (IDLE): snapshot pend_cnt = FIFO count + (same-cycle push) - (same-cycle pop).
//   - snapshot==0: redirect next cycle, state stays IDLE.
//   - otherwise -> PEND, fetch_stall_o=1. pend_cnt decrements on each upd_valid_o&upd_ready_i.
//     Redirect issues the cycle after pend_cnt reaches 0, then -> IDLE.
//   - Updates accepted after the restart do not delay it.
//  Illegal restart_cause_i (NONE/FLUSH) is an assertion failure; treat as INV_INSTR.
//  FIFO:
//   - push on pr_valid_i&pr_ready_o; pop on upd_valid_o&upd_ready_i.
//   - pr_ready_o = !full from the registered count; no same-cycle pop credit when full.
//   - upd_valid_o=!empty; upd_o=head; pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
//   - Push and pop in the same cycle while neither full nor empty: count unchanged.
//  redirect_* outputs are registered. redirect_pc_o and redirect_cause_o hold their last value when redirect_valid_o=0.
// CONFIGURATION
//  IF_REDIRECT_UPD_BYPASS_EN defined:
//   - FIFO empty & pr_valid_i & upd_ready_i: the update passes combinationally to upd_o, with no push.
//   - This bypass counts as a pop for the pend_cnt snapshot.
//  Not defined: updates are always registered through the FIFO; minimum update latency is 1 cycle.
// STRUCTURE
//  Shared IF package gains:
//   - redirect_cause_e (3b: NONE=0, FLUSH=1, INV_INSTR=2, INV_PRED=3, CALL=4, RET=5);
//   - redirect_s {pc, cause};
//   - arb_state_e;
//   - the existing predictor_update typedef (72b).
//  One sub-module: pr_update_fifo (generic sync FIFO, DEPTH/WIDTH parameters, count output).
// TESTING
//  1. Reset, then flush_pc_i=0x100 at cycle 5
//     -> redirect pulse cycle 6 pc=0x100 cause=FLUSH; fetch_stall_o=1 cycles 6-7; restart_ready_o=1 at cycle 8.
//  2. Three updates pushed with upd_ready_i=0, then restart pc=0x200 INV_PRED; upd_ready_i=1 two cycles later
//     -> three updates drain in order; redirect exactly 1 cycle after the 3rd handshake.
//  3. flush 0x300 and restart 0x400 in the same cycle -> only flush redirect 0x300 issued; the restart is not accepted.
//  4. Restart pending in PEND, flush 0x500 -> the pending restart is never issued; the 0x500 redirect follows.
//  5. Push 4 updates with upd_ready_i=0 -> pr_ready_o=0 after the 4th push;
//     one pop re-raises it the next cycle; no drops or duplicates; pointers wrap correctly over 10 pushes.
//  6. With IF_REDIRECT_UPD_BYPASS_EN, FIFO empty, pr_valid_i=1, upd_ready_i=1
//     -> upd_o equals pr_update_i in the same cycle. Without the macro -> it appears 1 cycle later.

Source files
------------

// File: rtl/if_redirect_arbiter_pkg.sv
// Shared IF-stage types for redirect arbitration: redirect causes, redirect record,
// arbiter FSM states and the 72-bit predictor update carried from commit to the predictors.
package if_redirect_arbiter_pkg;

  localparam int IF_PC_BITS    = 32;
  localparam int PRED_UPD_BITS = 72;

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_FLUSH     = 3'd1,
    CAUSE_INV_INSTR = 3'd2,
    CAUSE_INV_PRED  = 3'd3,
    CAUSE_CALL      = 3'd4,
    CAUSE_RET       = 3'd5
  } redirect_cause_e;

  typedef struct packed {
    logic [IF_PC_BITS-1:0] pc;
    redirect_cause_e       cause;
  } redirect_s;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_PEND = 2'd1,
    ARB_HOLD = 2'd2
  } arb_state_e;

  // kind selects BTB / gshare / RAS; ras_ptr is only meaningful for RAS updates
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [2:0]  kind;
    logic        taken;
    logic [3:0]  ras_ptr;
  } predictor_update;

  function automatic logic restart_cause_legal(input logic [2:0] cause);
    return (cause == CAUSE_INV_INSTR) || (cause == CAUSE_INV_PRED) ||
           (cause == CAUSE_CALL)      || (cause == CAUSE_RET);
  endfunction

  function automatic redirect_cause_e sanitize_restart_cause(input logic [2:0] cause);
    return restart_cause_legal(cause) ? redirect_cause_e'(cause) : CAUSE_INV_INSTR;
  endfunction

endpackage

// File: rtl/if_redirect_arbiter_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally. Push when full and pop when empty are ignored.
module pr_update_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 72,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count and pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_redirect_arbiter.sv
// Arbitrates flush, restart and predictor-update traffic into one registered redirect per cycle.
// Optional IF_REDIRECT_UPD_BYPASS_EN lets an update skip an empty FIFO combinationally.
module if_redirect_arbiter
  import if_redirect_arbiter_pkg::*;
#(
  parameter int PC_BITS            = 32,
  parameter int UPD_FIFO_DEPTH     = 4,
  parameter int FLUSH_STALL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_valid_i,
  input  logic [PC_BITS-1:0] flush_pc_i,
  input  logic               restart_valid_i,
  output logic               restart_ready_o,
  input  logic [PC_BITS-1:0] restart_pc_i,
  input  logic [2:0]         restart_cause_i,
  input  logic               pr_valid_i,
  output logic               pr_ready_o,
  input  predictor_update    pr_update_i,
  output logic               upd_valid_o,
  input  logic               upd_ready_i,
  output predictor_update    upd_o,
  output logic               redirect_valid_o,
  output logic [PC_BITS-1:0] redirect_pc_o,
  output redirect_cause_e    redirect_cause_o,
  output logic               fetch_stall_o
);

  localparam int CNT_W  = $clog2(UPD_FIFO_DEPTH + 1);
  localparam int HOLD_W = $clog2(FLUSH_STALL_CYCLES + 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   pend_cnt_q, pend_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [PC_BITS-1:0] pend_pc_q, pend_pc_d;
  redirect_cause_e    pend_cause_q, pend_cause_d;
  logic               redir_valid_d;
  logic [PC_BITS-1:0] redir_pc_d;
  redirect_cause_e    redir_cause_d;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]   fifo_count;
  predictor_update    fifo_head;
  logic               bypass, pr_accept, upd_fire, restart_fire;
  logic [CNT_W-1:0]   snapshot;
  redirect_cause_e    restart_cause;

`ifdef IF_REDIRECT_UPD_BYPASS_EN
  assign bypass = rst_n & fifo_empty & pr_valid_i & upd_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign pr_ready_o      = rst_n & ~fifo_full;
  assign pr_accept       = pr_valid_i & pr_ready_o;
  assign fifo_push       = pr_accept & ~bypass;
  assign upd_valid_o     = ~fifo_empty | bypass;
  assign upd_o           = bypass ? pr_update_i : fifo_head;
  assign upd_fire        = upd_valid_o & upd_ready_i;
  assign fifo_pop        = upd_fire & ~bypass;

  assign restart_ready_o = rst_n & (state_q == ARB_IDLE) & ~flush_valid_i;
  assign restart_fire    = restart_valid_i & restart_ready_o;
  assign restart_cause   = sanitize_restart_cause(restart_cause_i);
  // Older updates still owed to the predictor once this cycle's push/pop settle
  assign snapshot        = fifo_count + CNT_W'(pr_accept) - CNT_W'(upd_fire);

  pr_update_fifo #(
    .DEPTH (UPD_FIFO_DEPTH),
    .WIDTH (PRED_UPD_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pr_update_i),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ARB_IDLE;
      pend_cnt_q       <= '0;
      hold_cnt_q       <= '0;
      pend_pc_q        <= '0;
      pend_cause_q     <= CAUSE_NONE;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      redirect_cause_o <= CAUSE_NONE;
    end else begin
      state_q          <= state_d;
      pend_cnt_q       <= pend_cnt_d;
      hold_cnt_q       <= hold_cnt_d;
      pend_pc_q        <= pend_pc_d;
      pend_cause_q     <= pend_cause_d;
      redirect_valid_o <= redir_valid_d;
      redirect_pc_o    <= redir_pc_d;
      redirect_cause_o <= redir_cause_d;
    end
  end

  // Flush overrides everything and drops a waiting restart
  always_comb begin
    state_d      = state_q;
    pend_cnt_d   = pend_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    pend_pc_d    = pend_pc_q;
    pend_cause_d = pend_cause_q;
    if (flush_valid_i) begin
      state_d    = ARB_HOLD;
      hold_cnt_d = HOLD_W'(FLUSH_STALL_CYCLES);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (restart_fire && (snapshot != '0)) begin
            state_d      = ARB_PEND;
            pend_cnt_d   = snapshot;
            pend_pc_d    = restart_pc_i;
            pend_cause_d = restart_cause;
          end
        end
        ARB_PEND: begin
          if (upd_fire) begin
            pend_cnt_d = pend_cnt_q - CNT_W'(1);
            if (pend_cnt_q == CNT_W'(1)) state_d = ARB_IDLE;
          end
        end
        ARB_HOLD: begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          if (hold_cnt_q == HOLD_W'(1)) state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // The pending restart fires on the edge that retires its last older update
  always_comb begin
    redir_valid_d = 1'b0;
    redir_pc_d    = redirect_pc_o;
    redir_cause_d = redirect_cause_o;
    fetch_stall_o = (state_q != ARB_IDLE);
    if (flush_valid_i) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = flush_pc_i;
      redir_cause_d = CAUSE_FLUSH;
    end else if (restart_fire && (snapshot == '0)) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = restart_pc_i;
      redir_cause_d = restart_cause;
    end else if ((state_q == ARB_PEND) && upd_fire && (pend_cnt_q == CNT_W'(1))) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = pend_pc_q;
      redir_cause_d = pend_cause_q;
    end
  end

  restart_cause_chk: assert property (@(posedge clk) disable iff (!rst_n)
    restart_fire |-> restart_cause_legal(restart_cause_i));

endmodule

// File: tb/tb_if_redirect_arbiter.sv
// Self-checking bench for if_redirect_arbiter: directed scenarios then random traffic,
// compared each cycle against a sequence-number based ordering model.
module tb_if_redirect_arbiter;
  import if_redirect_arbiter_pkg::*;

  localparam int PC_BITS = 32;
  localparam int DEPTH   = 4;
  localparam int STALL   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush_valid_i = 1'b0;
  logic [PC_BITS-1:0] flush_pc_i = '0;
  logic               restart_valid_i = 1'b0;
  logic               restart_ready_o;
  logic [PC_BITS-1:0] restart_pc_i = '0;
  logic [2:0]         restart_cause_i = 3'd2;
  logic               pr_valid_i = 1'b0;
  logic               pr_ready_o;
  predictor_update    pr_update_i = '0;
  logic               upd_valid_o;
  logic               upd_ready_i = 1'b0;
  predictor_update    upd_o;
  logic               redirect_valid_o;
  logic [PC_BITS-1:0] redirect_pc_o;
  redirect_cause_e    redirect_cause_o;
  logic               fetch_stall_o;

  always #5 clk = ~clk;

  if_redirect_arbiter #(
    .PC_BITS            (PC_BITS),
    .UPD_FIFO_DEPTH     (DEPTH),
    .FLUSH_STALL_CYCLES (STALL)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_valid_i    (flush_valid_i),
    .flush_pc_i       (flush_pc_i),
    .restart_valid_i  (restart_valid_i),
    .restart_ready_o  (restart_ready_o),
    .restart_pc_i     (restart_pc_i),
    .restart_cause_i  (restart_cause_i),
    .pr_valid_i       (pr_valid_i),
    .pr_ready_o       (pr_ready_o),
    .pr_update_i      (pr_update_i),
    .upd_valid_o      (upd_valid_o),
    .upd_ready_i      (upd_ready_i),
    .upd_o            (upd_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_cause_o (redirect_cause_o),
    .fetch_stall_o    (fetch_stall_o)
  );

  int testCount = 0;
  int failCount = 0;

  // Model: every accepted update gets a sequence number; a restart waits until every
  // update numbered at or below its barrier has been handed to the predictor.
  logic [71:0] qData[$];
  int          qSeq[$];
  int          nextSeq = 0;
  int          lastAccepted = -1;
  bit          pending = 0;
  int          barrier = -1;
  logic [31:0] pendPc = '0;
  logic [2:0]  pendCause = '0;
  int          holdLeft = 0;
  logic        expRedValid = 1'b0;
  logic [31:0] expRedPc = '0;
  logic [2:0]  expRedCause = '0;
  logic        expPrReady, expRestartReady, expUpdValid, expStall, expBypass;
  logic [71:0] expUpd;

  function automatic bit olderDrained(input int b);
    return (qSeq.size() == 0) || (qSeq[0] > b);
  endfunction

  function automatic void computeExpect();
    expBypass = 1'b0;
`ifdef IF_REDIRECT_UPD_BYPASS_EN
    expBypass = rst_n && (qData.size() == 0) && pr_valid_i && upd_ready_i;
`endif
    expPrReady      = rst_n && (qData.size() < DEPTH);
    expUpdValid     = (qData.size() > 0) || expBypass;
    expUpd          = expBypass ? 72'(pr_update_i) : ((qData.size() > 0) ? qData[0] : 72'd0);
    expRestartReady = rst_n && !pending && (holdLeft == 0) && !flush_valid_i;
    expStall        = pending || (holdLeft > 0);
  endfunction

  function automatic void modelEdge();
    if (!rst_n) begin
      qData.delete();
      qSeq.delete();
      pending     = 0;
      holdLeft    = 0;
      expRedValid = 1'b0;
      expRedPc    = '0;
      expRedCause = '0;
      return;
    end
    if (expBypass) begin
      lastAccepted = nextSeq;
      nextSeq++;
    end else begin
      if (expUpdValid && upd_ready_i) begin
        void'(qData.pop_front());
        void'(qSeq.pop_front());
      end
      if (pr_valid_i && expPrReady) begin
        qData.push_back(72'(pr_update_i));
        qSeq.push_back(nextSeq);
        lastAccepted = nextSeq;
        nextSeq++;
      end
    end
    expRedValid = 1'b0;
    if (flush_valid_i) begin
      expRedValid = 1'b1;
      expRedPc    = flush_pc_i;
      expRedCause = 3'd1;
      holdLeft    = STALL;
      pending     = 0;
    end else if (restart_valid_i && expRestartReady) begin
      if (olderDrained(lastAccepted)) begin
        expRedValid = 1'b1;
        expRedPc    = restart_pc_i;
        expRedCause = restart_cause_i;
      end else begin
        pending   = 1;
        barrier   = lastAccepted;
        pendPc    = restart_pc_i;
        pendCause = restart_cause_i;
      end
    end else if (pending) begin
      if (olderDrained(barrier)) begin
        expRedValid = 1'b1;
        expRedPc    = pendPc;
        expRedCause = pendCause;
        pending     = 0;
      end
    end else if (holdLeft > 0) begin
      holdLeft--;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model for the current cycle
  task automatic checkAll();
    computeExpect();
    checkOutput("restart_ready", 72'(restart_ready_o), 72'(expRestartReady));
    checkOutput("pr_ready", 72'(pr_ready_o), 72'(expPrReady));
    checkOutput("upd_valid", 72'(upd_valid_o), 72'(expUpdValid));
    if (expUpdValid) checkOutput("upd_data", 72'(upd_o), expUpd);
    checkOutput("redirect_valid", 72'(redirect_valid_o), 72'(expRedValid));
    checkOutput("redirect_pc", 72'(redirect_pc_o), 72'(expRedPc));
    checkOutput("redirect_cause", 72'(redirect_cause_o), 72'(expRedCause));
    checkOutput("fetch_stall", 72'(fetch_stall_o), 72'(expStall));
  endtask

  // One clock of stimulus: drive, check after settling, advance model on the edge
  task automatic applyStimulus(input logic fv, input logic [31:0] fpc,
                               input logic rv, input logic [31:0] rpc, input logic [2:0] rc,
                               input logic pv, input logic ur);
    flush_valid_i   = fv;
    flush_pc_i      = fpc;
    restart_valid_i = rv;
    restart_pc_i    = rpc;
    restart_cause_i = rc;
    pr_valid_i      = pv;
    pr_update_i     = predictor_update'({$urandom(), $urandom(), 8'($urandom())});
    upd_ready_i     = ur;
    #1;
    checkAll();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle(input int n, input logic ur);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 3'd2, 0, ur);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held: readies must be low
    rst_n = 1'b0;
    idle(3, 0);
    rst_n = 1'b1;
    // Scenario 1: flush, two stall cycles, then restart ready again
    idle(2, 0);
    applyStimulus(1, 32'h100, 0, 0, 3'd2, 0, 0);
    idle(4, 0);
    // Scenario 2: three queued updates must drain before the restart redirect
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 3'd2, 1, 0);
    applyStimulus(0, 0, 1, 32'h200, 3'd3, 0, 0);
    idle(1, 0);
    idle(5, 1);
    // Scenario 3: simultaneous flush and restart, only flush wins
    applyStimulus(1, 32'h300, 1, 32'h400, 3'd4, 0, 1);
    idle(3, 1);
    // Scenario 4: flush cancels a restart waiting in PEND
    applyStimulus(0, 0, 0, 0, 3'd2, 1, 0);
    applyStimulus(0, 0, 0, 0, 3'd2, 1, 0);
    applyStimulus(0, 0, 1, 32'h450, 3'd4, 0, 0);
    idle(1, 0);
    applyStimulus(1, 32'h500, 0, 0, 3'd2, 0, 0);
    idle(5, 1);
    // Scenario 5: fill the FIFO, offer a fifth, pop once, then wrap the pointers
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 3'd2, 1, 0);
    applyStimulus(0, 0, 0, 0, 3'd2, 0, 1);
    idle(1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 3'd2, 1, logic'(i % 2));
    idle(6, 1);
    // Scenario 6: empty FIFO, update offered with predictor ready
    applyStimulus(0, 0, 0, 0, 3'd2, 1, 1);
    idle(2, 1);
    // Reset in the middle of a pending restart drops it and the FIFO
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 3'd2, 1, 0);
    applyStimulus(0, 0, 1, 32'h600, 3'd5, 0, 0);
    rst_n = 1'b0;
    idle(1, 0);
    rst_n = 1'b1;
    idle(3, 1);
    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      applyStimulus($urandom_range(0, 15) == 0, $urandom(),
                    $urandom_range(0, 2) == 0, $urandom(), 3'(2 + $urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
    rst_n = 1'b1;
    idle(8, 1);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
